// File: rtl/varredura_matriz_caixa_pkg.sv
// Shared definitions for the LED matrix scan controller.
//   - FSM state encoding (OCIOSO, APAGADO, ACESO)
//   - matrix geometry (N_COL columns, N_LIN rows)
//   - COL0: one-hot select of the first column
//   - proxima_coluna: one-hot column rotation 0->1->2->3->4->0
package varredura_matriz_caixa_pkg;

  localparam logic [1:0] EST_OCIOSO  = 2'd0;
  localparam logic [1:0] EST_APAGADO = 2'd1;
  localparam logic [1:0] EST_ACESO   = 2'd2;

  typedef enum logic [1:0] {
    OCIOSO  = EST_OCIOSO,
    APAGADO = EST_APAGADO,
    ACESO   = EST_ACESO
  } estado_t;

  localparam int N_COL = 5;
  localparam int N_LIN = 7;

  localparam logic [N_COL-1:0] COL0 = 5'b00001;

  function automatic logic [N_COL-1:0] proxima_coluna(input logic [N_COL-1:0] c);
    return {c[N_COL-2:0], c[N_COL-1]};
  endfunction

endpackage

// File: rtl/varredura_matriz_caixa_sincronizador_2ff.sv
// 1-bit two-flop synchroniser for an asynchronous input.
// Ports:
//   clk   - destination clock
//   reset - asynchronous, active-high; clears both flops
//   d     - asynchronous input
//   q     - synchronised output (two clk cycles of latency)
module sincronizador_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/varredura_matriz_caixa.sv
// Scan controller for the 5x7 LED matrix showing the tank level.
// Synchronises the three level sensors, freezes them once per frame, walks a
// one-hot column select across the matrix with blanking between columns, and
// registers the row pattern returned by the external decoder.
// Ports:
//   clk, reset          - system clock, asynchronous active-high reset
//   enable              - scan enable (level)
//   alto_in/medio_in/baixo_in - raw asynchronous level sensors
//   linhas              - row pattern from the decoder for current col_sel
//   alto/medio/baixo    - frame-frozen sensor snapshot, to decoder
//   col_sel             - one-hot column index, to decoder
//   col_drv, lin_drv    - registered matrix drivers (active high)
//   frame_start         - one-cycle pulse when a frame begins
//   sensor_erro         - snapshot is physically inconsistent
//
// state   | meaning
// OCIOSO  | scan stopped, drivers off
// APAGADO | blanking, drivers off, decoder settling on col_sel
// ACESO   | column lit with the pattern latched at end of blanking
module varredura_matriz_caixa
  import varredura_matriz_caixa_pkg::*;
#(
  parameter int DWELL_CYCLES = 10000,
  parameter int BLANK_CYCLES = 50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             alto_in,
  input  logic             medio_in,
  input  logic             baixo_in,
  input  logic [N_LIN-1:0] linhas,
  output logic             alto,
  output logic             medio,
  output logic             baixo,
  output logic [N_COL-1:0] col_sel,
  output logic [N_COL-1:0] col_drv,
  output logic [N_LIN-1:0] lin_drv,
  output logic             frame_start,
  output logic             sensor_erro
);

  localparam int WB = $clog2(BLANK_CYCLES);
  localparam int WD = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [WB-1:0] BLANK_ULT = WB'(BLANK_CYCLES - 1);
  localparam logic [WD-1:0] DWELL_ULT = WD'(DWELL_CYCLES - 1);

  estado_t          estado, estado_nxt;
  logic [WB-1:0]    cnt_blank, cnt_blank_nxt;
  logic [WD-1:0]    cnt_dwell, cnt_dwell_nxt;
  logic [N_COL-1:0] col_sel_nxt, col_drv_nxt;
  logic [N_LIN-1:0] lin_drv_nxt;
  logic             inicio_quadro;
  logic             alto_s, medio_s, baixo_s;

  sincronizador_2ff u_sinc_alto  (.clk(clk), .reset(reset), .d(alto_in),  .q(alto_s));
  sincronizador_2ff u_sinc_medio (.clk(clk), .reset(reset), .d(medio_in), .q(medio_s));
  sincronizador_2ff u_sinc_baixo (.clk(clk), .reset(reset), .d(baixo_in), .q(baixo_s));

  always_comb begin
    estado_nxt    = estado;
    cnt_blank_nxt = cnt_blank;
    cnt_dwell_nxt = cnt_dwell;
    col_sel_nxt   = col_sel;
    col_drv_nxt   = col_drv;
    lin_drv_nxt   = lin_drv;
    inicio_quadro = 1'b0;

    if (!enable) begin
      estado_nxt    = OCIOSO;
      cnt_blank_nxt = '0;
      cnt_dwell_nxt = '0;
      col_sel_nxt   = COL0;
      col_drv_nxt   = '0;
      lin_drv_nxt   = '0;
    end else begin
      case (estado)
        OCIOSO: begin
          estado_nxt    = APAGADO;
          cnt_blank_nxt = '0;
          cnt_dwell_nxt = '0;
          col_sel_nxt   = COL0;
          col_drv_nxt   = '0;
          lin_drv_nxt   = '0;
          inicio_quadro = 1'b1;
        end
        APAGADO: begin
          if (cnt_blank == BLANK_ULT) begin
            // decoder has had the whole blanking window to settle on col_sel
            estado_nxt    = ACESO;
            cnt_blank_nxt = '0;
            cnt_dwell_nxt = '0;
            col_drv_nxt   = col_sel;
            lin_drv_nxt   = linhas;
          end else begin
            cnt_blank_nxt = cnt_blank + 1'b1;
          end
        end
        ACESO: begin
          if (cnt_dwell == DWELL_ULT) begin
            estado_nxt    = APAGADO;
            cnt_dwell_nxt = '0;
            cnt_blank_nxt = '0;
            col_drv_nxt   = '0;
            lin_drv_nxt   = '0;
            col_sel_nxt   = proxima_coluna(col_sel);
            // leaving the last column wraps to column 0: new frame
            inicio_quadro = col_sel[N_COL-1];
          end else begin
            cnt_dwell_nxt = cnt_dwell + 1'b1;
          end
        end
        default: estado_nxt = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado      <= OCIOSO;
      cnt_blank   <= '0;
      cnt_dwell   <= '0;
      col_sel     <= COL0;
      col_drv     <= '0;
      lin_drv     <= '0;
      frame_start <= 1'b0;
      alto        <= 1'b0;
      medio       <= 1'b0;
      baixo       <= 1'b0;
      sensor_erro <= 1'b0;
    end else begin
      estado      <= estado_nxt;
      cnt_blank   <= cnt_blank_nxt;
      cnt_dwell   <= cnt_dwell_nxt;
      col_sel     <= col_sel_nxt;
      col_drv     <= col_drv_nxt;
      lin_drv     <= lin_drv_nxt;
      frame_start <= inicio_quadro;
      // snapshot only moves at frame boundaries so every column shows one level
      if (inicio_quadro) begin
        alto        <= alto_s;
        medio       <= medio_s;
        baixo       <= baixo_s;
        sensor_erro <= (alto_s & ~medio_s) | (medio_s & ~baixo_s);
      end
    end
  end

endmodule

// File: doc/varredura_matriz_caixa.md
Name: varredura_matriz_caixa

Overview:
- Sequential scan controller driving the 5x7 LED matrix that shows the tank level.
- Synchronises the three level sensors and freezes them per frame. Walks a one-hot column select through columns 0..4, feeds the level snapshot and column select to the combinational row decoder, and registers the returned row pattern onto the matrix drivers.
- Inserts blanking between columns to prevent ghosting.

Parameters:
- DWELL_CYCLES, 10000: clock cycles a column stays lit; must be >= 1.
- BLANK_CYCLES, 50: clock cycles with all drivers off before each column; must be >= 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  scan enable, level-sensitive.
- alto_in  input  1  raw high-level sensor, asynchronous.
- medio_in  input  1  raw mid-level sensor, asynchronous.
- baixo_in  input  1  raw low-level sensor, asynchronous.
- linhas  input  7  row pattern from decoder (bit i = row i) for the current col_sel.
- alto  output  1  frame-frozen high sensor, to decoder.
- medio  output  1  frame-frozen mid sensor, to decoder.
- baixo  output  1  frame-frozen low sensor, to decoder.
- col_sel  output  5  one-hot column index, to decoder.
- col_drv  output  5  one-hot column driver, to matrix; active high.
- lin_drv  output  7  registered row driver, to matrix; active high.
- frame_start  output  1  one-cycle pulse at the start of each frame.
- sensor_erro  output  1  snapshot is physically inconsistent.

Behaviour:
- Reset (async, active-high):
  - state=OCIOSO, column index=0, col_sel=5'b00001.
  - col_drv=0, lin_drv=0, alto=medio=baixo=0.
  - frame_start=0, sensor_erro=0, both counters=0, synchroniser flops=0.
- Sensor path:
  - Two-flop synchroniser per sensor.
  - Snapshot registers alto/medio/baixo load the synchronised values only on the cycle frame_start pulses; they hold otherwise.
  - sensor_erro is registered and updates with the snapshot: (alto & ~medio) | (medio & ~baixo).
- FSM states: OCIOSO, APAGADO, ACESO.
  - OCIOSO: drivers 0.
    - enable=1 -> APAGADO with column 0.
    - frame_start pulses on this transition; the snapshot loads.
  - APAGADO: col_drv=0, lin_drv=0; col_sel shows the current column so the decoder settles.
    - Counter runs 0..BLANK_CYCLES-1.
    - On the last count, lin_drv <= linhas and col_drv <= col_sel at that edge, then -> ACESO.
    - Decoder-to-driver latency: linhas is sampled at the final APAGADO edge. Changes to linhas during ACESO are ignored.
  - ACESO: col_drv and lin_drv are held for DWELL_CYCLES cycles. At the end:
    - col_drv=0 and lin_drv=0.
    - The column advances: 0->1->2->3->4->0; the 4->0 step is the wrap.
    - -> APAGADO.
    - On the wrap, frame_start pulses and the snapshot loads in the same cycle col_sel returns to 5'b00001.
- Frame period: 5*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- enable deasserted in any state:
  - Next edge -> OCIOSO; drivers cleared, counters cleared, column=0.
  - Snapshot and sensor_erro hold.
  - No frame_start.
- enable reasserted: a new frame starts at column 0 per the OCIOSO rule.
- Invariants:
  - col_sel is always exactly one-hot.
  - col_drv is one-hot or zero, never multi-hot.
  - col_drv equals col_sel whenever nonzero.
- Snapshot is never updated mid-frame, so all five columns render the same level.
- Asynchronous reset mid-column forces the reset state immediately; no partial column completes.

Decomposition:
- Shared package:
  - state encoding localparams for OCIOSO, APAGADO, ACESO.
  - N_COL=5, N_LIN=7.
  - COL0 one-hot constant.
- One sub-module: sincronizador_2ff, a 1-bit two-flop synchroniser with the same clk and reset. It is instantiated three times.
- Counters and FSM stay in the top module.

Test Plan (DWELL_CYCLES=4, BLANK_CYCLES=2, decoder modelled in the bench):
- reset=1 mid-ACESO -> all outputs 0 immediately, col_sel=00001, no clock edge needed.
- enable=1 after reset -> frame_start for 1 cycle. col_drv=0 for 2 cycles, then col_drv=00001 for 4 cycles, then 00010 after 2 blank cycles. Frame period 30 cycles.
- Sensors alto=0, medio=1, baixo=1 stable -> snapshot=(0,1,1) three cycles after the frame start following the change (2 synchroniser cycles plus snapshot load), sensor_erro=0. Each column's lin_drv equals the decoder output for that col_sel.
- Toggle medio_in mid-frame -> alto/medio/baixo unchanged until the next frame_start, which occurs when col_sel wraps 10000->00001.
- alto_in=1, medio_in=0 held -> sensor_erro=1 from the next frame; scanning continues.
- enable=0 during ACESO on column 3 -> next edge: col_drv=0, lin_drv=0, col_sel=00001. Re-enable -> restart at column 0 with frame_start.
